// File: rtl/rf_write_queue_if.sv
// Pipeline/register-file side signals of rf_write_queue, bundled with master (pipeline/decode)
// and slave (queue) views.
interface rf_write_queue_if #(
  parameter int DEPTH = 4,
  parameter int PW    = 2
);
  logic          enq_valid;
  logic [2:0]    enq_reg;
  logic [15:0]   enq_data;
  logic          enq_ready;
  logic          drain_en;
  logic          write;
  logic [2:0]    writeregsel;
  logic [15:0]   writedata;
  logic [2:0]    look1sel;
  logic [2:0]    look2sel;
  logic          look1hit;
  logic          look2hit;
  logic [15:0]   look1data;
  logic [15:0]   look2data;
  logic [PW:0]   count;
  logic          err;

  modport master (
    output enq_valid, enq_reg, enq_data, drain_en, look1sel, look2sel,
    input  enq_ready, write, writeregsel, writedata,
           look1hit, look2hit, look1data, look2data, count, err
  );

  modport slave (
    input  enq_valid, enq_reg, enq_data, drain_en, look1sel, look2sel,
    output enq_ready, write, writeregsel, writedata,
           look1hit, look2hit, look1data, look2data, count, err
  );
endinterface

// File: rtl/rf_write_queue.sv
// In-order write-back queue in front of the 8x16 register file, with two forwarding lookups.
// Optional feature macro: RFWQ_BYPASS_EN (builds the lookup comparators when defined).
module rf_write_queue #(
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic           clk,
  input  logic           rst,
  rf_write_queue_if.slave q
);

  typedef struct packed {
    logic [2:0]  regsel;
    logic [15:0] data;
  } entry_t;

  // NOTE: storage is not reset; occupancy alone decides which entries are valid.
  entry_t         r_mem [DEPTH];
  logic [PW-1:0]  r_rd_ptr;
  logic [PW-1:0]  r_wr_ptr;
  logic [PW:0]    r_cnt;
  logic           r_err;

  logic           w_full;
  logic           w_empty;
  logic           w_enq;
  logic           w_deq;
  entry_t         w_head;

  assign w_full  = (r_cnt == (PW+1)'(DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_enq   = q.enq_valid && !w_full;
  assign w_deq   = !w_empty && q.drain_en;
  assign w_head  = r_mem[r_rd_ptr];

  assign q.enq_ready   = !w_full;
  assign q.count       = r_cnt;
  assign q.err         = r_err;
  assign q.write       = w_deq;
  assign q.writeregsel = w_deq ? w_head.regsel : 3'd0;
  assign q.writedata   = w_deq ? w_head.data   : 16'd0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_enq && !w_deq)      r_cnt <= r_cnt + 1'b1;
      else if (w_deq && !w_enq) r_cnt <= r_cnt - 1'b1;
      if (q.enq_valid && w_full) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && w_enq) r_mem[r_wr_ptr] <= '{regsel: q.enq_reg, data: q.enq_data};
  end

`ifdef RFWQ_BYPASS_EN
  typedef struct packed {
    logic        hit;
    logic [15:0] data;
  } look_t;

  // Walk oldest to youngest so the youngest matching entry overwrites earlier matches.
  function automatic look_t lookup(input logic [2:0] sel);
    look_t         res;
    logic [PW-1:0] idx;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = r_rd_ptr + PW'(i);
      if (((PW+1)'(i) < r_cnt) && (r_mem[idx].regsel == sel)) begin
        res.hit  = 1'b1;
        res.data = r_mem[idx].data;
      end
    end
    return res;
  endfunction

  look_t w_look1;
  look_t w_look2;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_look1 = '0;
    w_look2 = '0;
    w_look1 = lookup(q.look1sel);
    w_look2 = lookup(q.look2sel);
  end

  assign q.look1hit  = w_look1.hit;
  assign q.look1data = w_look1.data;
  assign q.look2hit  = w_look2.hit;
  assign q.look2data = w_look2.data;
`else
  logic w_unused_look;
  assign w_unused_look = ^{q.look1sel, q.look2sel};

  assign q.look1hit  = 1'b0;
  assign q.look1data = 16'd0;
  assign q.look2hit  = 1'b0;
  assign q.look2data = 16'd0;
`endif

endmodule

// File: tb/tb_rf_write_queue.sv
// Self-checking bench for rf_write_queue: directed test-plan scenarios plus random traffic
// compared against a queue-based reference model.
module tb_rf_write_queue;
  localparam int DEPTH = 4;
  localparam int PW    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  rf_write_queue_if #(.DEPTH(DEPTH), .PW(PW)) ifc ();

  rf_write_queue #(.DEPTH(DEPTH), .PW(PW)) dut (
    .clk (clk),
    .rst (rst),
    .q   (ifc.slave)
  );

  always #5 clk = ~clk;

  // Reference model: a plain FIFO of {reg, data} plus a sticky error bit.
  logic [18:0] mq[$];
  logic        m_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] model_look(input logic [2:0] sel);
    logic [16:0] r;
    r = '0;
`ifdef RFWQ_BYPASS_EN
    foreach (mq[i]) if (mq[i][18:16] == sel) r = {1'b1, mq[i][15:0]};
`endif
    return r;
  endfunction

  task automatic compare_outputs();
    logic        exp_wr;
    logic [16:0] l1, l2;
    exp_wr = (mq.size() != 0) && ifc.drain_en;
    l1 = model_look(ifc.look1sel);
    l2 = model_look(ifc.look2sel);
    check("write",       32'(ifc.write),       32'(exp_wr));
    check("writeregsel", 32'(ifc.writeregsel), exp_wr ? 32'(mq[0][18:16]) : 32'd0);
    check("writedata",   32'(ifc.writedata),   exp_wr ? 32'(mq[0][15:0])  : 32'd0);
    check("count",       32'(ifc.count),       32'(mq.size()));
    check("enq_ready",   32'(ifc.enq_ready),   32'(mq.size() < DEPTH));
    check("err",         32'(ifc.err),         32'(m_err));
    check("look1hit",    32'(ifc.look1hit),    32'(l1[16]));
    check("look1data",   32'(ifc.look1data),   32'(l1[15:0]));
    check("look2hit",    32'(ifc.look2hit),    32'(l2[16]));
    check("look2data",   32'(ifc.look2data),   32'(l2[15:0]));
  endtask

  // One clock: drive inputs, check combinational outputs mid-cycle, then advance the model.
  task automatic cycle(input logic ev, input logic [2:0] er, input logic [15:0] ed,
                       input logic de, input logic [2:0] s1, input logic [2:0] s2);
    logic do_deq;
    ifc.enq_valid = ev;
    ifc.enq_reg   = er;
    ifc.enq_data  = ed;
    ifc.drain_en  = de;
    ifc.look1sel  = s1;
    ifc.look2sel  = s2;
    #2;
    compare_outputs();
    do_deq = (mq.size() != 0) && de;
    @(posedge clk);
    if (ev && mq.size() == DEPTH) m_err = 1'b1;
    else if (ev) mq.push_back({er, ed});
    if (do_deq) void'(mq.pop_front());
    #1;
  endtask

  task automatic do_reset(input logic ev, input logic de);
    rst           = 1'b0;
    ifc.enq_valid = ev;
    ifc.enq_reg   = 3'd7;
    ifc.enq_data  = 16'hDEAD;
    ifc.drain_en  = de;
    @(posedge clk);
    mq.delete();
    m_err = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  initial begin
    ifc.enq_valid = 1'b0;
    ifc.enq_reg   = '0;
    ifc.enq_data  = '0;
    ifc.drain_en  = 1'b0;
    ifc.look1sel  = '0;
    ifc.look2sel  = '0;

    // Reset state
    @(posedge clk);
    do_reset(1'b0, 1'b0);
    #1;
    check("rst_count", 32'(ifc.count), 32'd0);
    check("rst_ready", 32'(ifc.enq_ready), 32'd1);
    check("rst_write", 32'(ifc.write), 32'd0);

    // Single enqueue, then one drain cycle; no fall-through while empty
    cycle(1'b1, 3'd3, 16'h1234, 1'b1, 3'd3, 3'd0);
    check("s1_count", 32'(ifc.count), 32'd1);
    cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 3'd0);
    check("s1_count_after", 32'(ifc.count), 32'd0);

    // Fill, overflow, drain in order
    for (int i = 1; i <= 4; i++) cycle(1'b1, 3'(i), 16'(i), 1'b0, 3'(i), 3'd2);
    check("s2_full_ready", 32'(ifc.enq_ready), 32'd0);
    cycle(1'b1, 3'd5, 16'hFFFF, 1'b1, 3'd5, 3'd1);
    check("s2_err", 32'(ifc.err), 32'd1);
    check("s2_count", 32'(ifc.count), 32'd3);
    for (int i = 0; i < 4; i++) cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 3'd5);

    // Youngest-match lookup across dequeues
    do_reset(1'b0, 1'b0);
    cycle(1'b1, 3'd2, 16'hAAAA, 1'b0, 3'd2, 3'd0);
    cycle(1'b1, 3'd2, 16'hBBBB, 1'b0, 3'd2, 3'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 3'd0);

    // Steady state: one in, one out per cycle across pointer wraps
    cycle(1'b1, 3'd0, 16'h5000, 1'b1, 3'd0, 3'd1);
    for (int i = 1; i < 20; i++) cycle(1'b1, 3'(i), 16'h5000 + 16'(i), 1'b1, 3'(i), 3'(i + 1));
    check("s4_count", 32'(ifc.count), 32'd1);
    check("s4_err", 32'(ifc.err), 32'd0);
    cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 3'd4);

    // Mid-operation reset discards pending entries
    for (int i = 0; i < 3; i++) cycle(1'b1, 3'(i + 4), 16'hC000 + 16'(i), 1'b0, 3'd4, 3'd6);
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 3'd5);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cycle(1'($urandom_range(0, 99) < 60), 3'($urandom), 16'($urandom),
            1'($urandom_range(0, 99) < 50), 3'($urandom), 3'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
